rx_byte_register: RTL and testbench

- Receive-side counterpart of the transmit byte register.
- Accepts destuffed, decoded serial bits LSB-first and assembles them into bytes.
- Routes the first byte of each packet to the receive FSM as the PID, data bytes to the RX FIFO, and the final two bytes out as the received CRC.
- Sits between the bit-level decoder (NRZI/unstuff) and the RX FSM/FIFO; delays data by two bytes so CRC bytes are never written to the FIFO.

---
 rtl/rx_byte_register_pkg.sv | 21 ++
 rtl/rx_byte_register_if.sv | 43 ++++
 rtl/rx_byte_register_sr.sv | 46 ++++
 rtl/rx_byte_register.sv | 134 +++++++++++++
 tb/tb_rx_byte_register.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rx_byte_register_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared types and constants for the receive byte register slice.
//   rx_state_t : packet-level state of the byte register
//   BYTE_W     : width of an assembled byte
//   CRC_BYTES  : number of trailing CRC bytes held back from the FIFO
//   DCOUNT_W   : width of the payload byte counter
// ---------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PID  = 2'd1,
        DATA = 2'd2
    } rx_state_t;

    localparam int BYTE_W    = 8;
    localparam int CRC_BYTES = 2;
    localparam int DCOUNT_W  = 7;

endpackage

// File: rtl/rx_byte_register_if.sv
// ---------------------------------------------------------------------------
// rx_byte_register_if
// Bundles the decoder-side strobes and the FSM/FIFO-side results of the
// receive byte register.
//   master : bit-level decoder / packet framing (drives strobes, sees results)
//   slave  : rx_byte_register
// Signals:
//   packet_start, packet_end, shift_enable, bit_in   decoder -> register
//   pid_byte/pid_valid, fifo_byte/fifo_wr,
//   crc_bytes/crc_valid, data_count, err_*           register -> FSM/FIFO
// ---------------------------------------------------------------------------
interface rx_byte_register_if;
    import rx_pkg::*;

    logic                  packet_start;
    logic                  packet_end;
    logic                  shift_enable;
    logic                  bit_in;

    logic [BYTE_W-1:0]     pid_byte;
    logic                  pid_valid;
    logic [BYTE_W-1:0]     fifo_byte;
    logic                  fifo_wr;
    logic [2*BYTE_W-1:0]   crc_bytes;
    logic                  crc_valid;
    logic [DCOUNT_W-1:0]   data_count;
    logic                  err_align;
    logic                  err_short;
    logic                  err_overflow;

    modport master (
        output packet_start, packet_end, shift_enable, bit_in,
        input  pid_byte, pid_valid, fifo_byte, fifo_wr, crc_bytes, crc_valid,
               data_count, err_align, err_short, err_overflow
    );

    modport slave (
        input  packet_start, packet_end, shift_enable, bit_in,
        output pid_byte, pid_valid, fifo_byte, fifo_wr, crc_bytes, crc_valid,
               data_count, err_align, err_short, err_overflow
    );

endinterface

// File: rtl/rx_byte_register_sr.sv
// ---------------------------------------------------------------------------
// flex_stp_sr
// Serial-to-parallel shift register.
//   clk, rst      : clock, asynchronous active-high reset
//   shift_enable  : accept serial_in this cycle
//   serial_in     : incoming bit
//   next_word     : register contents including this cycle's accepted bit,
//                   so a caller can capture a word on its completing strobe
// SHIFT_MSB = 0 shifts towards the LSB (first bit ends up in bit 0 once the
// word is full); SHIFT_MSB = 1 shifts towards the MSB.
// ---------------------------------------------------------------------------
module flex_stp_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] next_word
);

    logic [NUM_BITS-1:0] sr;
    logic [NUM_BITS-1:0] shifted;

    generate
        if (SHIFT_MSB) begin : g_msb
            assign shifted = {sr[NUM_BITS-2:0], serial_in};
        end else begin : g_lsb
            assign shifted = {serial_in, sr[NUM_BITS-1:1]};
        end
    endgenerate

    assign next_word = shift_enable ? shifted : sr;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (shift_enable) begin
            sr <= shifted;
        end
    end

endmodule

// File: rtl/rx_byte_register.sv
// ---------------------------------------------------------------------------
// rx_byte_register
// Assembles decoded serial bits (LSB first) into bytes. The first byte of a
// packet is the PID, the last two are the CRC, everything between goes to the
// RX FIFO. Payload bytes are delayed two bytes deep so CRC bytes never reach
// the FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.slave  : packet_start/packet_end/shift_enable/bit_in in;
//                pid_byte/pid_valid, fifo_byte/fifo_wr, crc_bytes/crc_valid,
//                data_count, err_align, err_short, err_overflow out
// NUM_BITS must equal rx_pkg::BYTE_W.
// ---------------------------------------------------------------------------
module rx_byte_register
    import rx_pkg::*;
#(
    parameter int NUM_BITS       = 8,
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic                clk,
    input  logic                rst,
    rx_byte_register_if.slave   bus
);

    localparam int                    CNT_W    = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(NUM_BITS - 1);
    localparam logic [DCOUNT_W-1:0]   MAX_CNT  = DCOUNT_W'(MAX_DATA_BYTES);
    localparam logic [1:0]            FULL     = 2'(CRC_BYTES);

    rx_state_t             state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [1:0]            fill;
    logic [BYTE_W-1:0]     hold0;   // newest held byte
    logic [BYTE_W-1:0]     hold1;   // oldest held byte
    logic [NUM_BITS-1:0]   new_byte;
    logic                  sr_shift;
    logic                  byte_done;

    // Start and end strobes win over a coincident bit, which is dropped.
    assign sr_shift  = bus.shift_enable && (state != IDLE) &&
                       !bus.packet_start && !bus.packet_end;
    assign byte_done = sr_shift && (bit_cnt == LAST_BIT);

    flex_stp_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (1'b0)
    ) u_sr (
        .clk          (clk),
        .rst          (rst),
        .shift_enable (sr_shift),
        .serial_in    (bus.bit_in),
        .next_word    (new_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the hold pipeline is a handful of flops, not a RAM, so it
            // is reset with everything else and never leaks a stale byte.
            state            <= IDLE;
            bit_cnt          <= '0;
            fill             <= '0;
            hold0            <= '0;
            hold1            <= '0;
            bus.pid_byte     <= '0;
            bus.pid_valid    <= 1'b0;
            bus.fifo_byte    <= '0;
            bus.fifo_wr      <= 1'b0;
            bus.crc_bytes    <= '0;
            bus.crc_valid    <= 1'b0;
            bus.data_count   <= '0;
            bus.err_align    <= 1'b0;
            bus.err_short    <= 1'b0;
            bus.err_overflow <= 1'b0;
        end else begin
            bus.pid_valid <= 1'b0;
            bus.fifo_wr   <= 1'b0;
            bus.crc_valid <= 1'b0;

            if (bus.packet_start) begin
                // Restart from any state; held bytes are discarded unwritten.
                state            <= PID;
                bit_cnt          <= '0;
                fill             <= '0;
                hold0            <= '0;
                hold1            <= '0;
                bus.data_count   <= '0;
                bus.err_align    <= 1'b0;
                bus.err_short    <= 1'b0;
                bus.err_overflow <= 1'b0;
            end else if (bus.packet_end && state != IDLE) begin
                if (bit_cnt != '0) begin
                    bus.err_align <= 1'b1;
                end
                // fill is always 0 in PID, so this covers both states.
                if (fill == FULL) begin
                    bus.crc_bytes <= {hold1, hold0};
                    bus.crc_valid <= 1'b1;
                end else if (fill == 2'd1) begin
                    bus.err_short <= 1'b1;
                end
                state   <= IDLE;
                bit_cnt <= '0;
            end else if (sr_shift) begin
                bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
                if (byte_done) begin
                    case (state)
                        PID: begin
                            bus.pid_byte  <= new_byte;
                            bus.pid_valid <= 1'b1;
                            state         <= DATA;
                        end
                        DATA: begin
                            hold1 <= hold0;
                            hold0 <= new_byte;
                            if (fill == FULL) begin
                                // The oldest byte is now known not to be CRC.
                                if (bus.data_count == MAX_CNT) begin
                                    bus.err_overflow <= 1'b1;
                                end else begin
                                    bus.fifo_byte  <= hold1;
                                    bus.fifo_wr    <= 1'b1;
                                    bus.data_count <= bus.data_count + 1'b1;
                                end
                            end else begin
                                fill <= fill + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_byte_register.sv
// ---------------------------------------------------------------------------
// tb_rx_byte_register
// Drives whole packets (byte lists plus optional trailing bits) into the
// receive byte register and compares the observed PID, FIFO writes, CRC and
// error flags with what the packet rules predict for that byte list.
// ---------------------------------------------------------------------------
module tb_rx_byte_register;
    import rx_pkg::*;

    localparam int MAX_DATA = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rx_byte_register_if bus ();

    rx_byte_register #(
        .NUM_BITS       (8),
        .MAX_DATA_BYTES (MAX_DATA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: only ever appends, the stimulus side takes snapshots.
    logic [7:0]  wr_q[$];
    int          pid_pulses = 0;
    int          crc_pulses = 0;
    logic [15:0] seen_crc   = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pid_valid) pid_pulses++;
            if (bus.fifo_wr)   wr_q.push_back(bus.fifo_byte);
            if (bus.crc_valid) begin
                crc_pulses++;
                seen_crc = bus.crc_bytes;
            end
        end
    end

    logic [15:0] model_crc = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.packet_start = 1'b1;
        tick();
        bus.packet_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        repeat ($urandom_range(0, 2)) tick();
        bus.shift_enable = 1'b1;
        bus.bit_in       = b;
        tick();
        bus.shift_enable = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) send_bit(b[k]);
    endtask

    task automatic pulse_end(input bit with_shift);
        bus.packet_end = 1'b1;
        if (with_shift) begin
            bus.shift_enable = 1'b1;
            bus.bit_in       = 1'($urandom);
        end
        tick();
        bus.packet_end   = 1'b0;
        bus.shift_enable = 1'b0;
    endtask

    task automatic run_packet(input string name, input logic [7:0] bytes[$],
                              input int extra, input bit end_with_shift);
        int pid0, crc0, wr0, n, pay, exp_wr, got_wr;
        bit exp_crc_v;
        logic [15:0] exp_crc;
        pid0 = pid_pulses;
        crc0 = crc_pulses;
        wr0  = wr_q.size();

        pulse_start();
        foreach (bytes[i]) send_byte(bytes[i]);
        for (int i = 0; i < extra; i++) send_bit(1'($urandom));
        pulse_end(end_with_shift);
        repeat (2) tick();

        // Packet rules: byte 0 is the PID, the last two bytes after it are the
        // CRC, the payload in between is written up to MAX_DATA bytes.
        n         = bytes.size();
        pay       = (n >= 1) ? n - 1 : 0;
        exp_wr    = (pay >= 2) ? ((pay - 2 > MAX_DATA) ? MAX_DATA : pay - 2) : 0;
        exp_crc_v = (pay >= 2);
        exp_crc   = exp_crc_v ? {bytes[n-2], bytes[n-1]} : model_crc;

        check({name, "/pid_pulses"}, pid_pulses - pid0, (n >= 1) ? 1 : 0);
        if (n >= 1) check({name, "/pid_byte"}, bus.pid_byte, bytes[0]);
        got_wr = wr_q.size() - wr0;
        check({name, "/fifo_wr_count"}, got_wr, exp_wr);
        for (int i = 0; i < exp_wr && i < got_wr; i++)
            check({name, "/fifo_byte"}, wr_q[wr0 + i], bytes[1 + i]);
        check({name, "/data_count"}, bus.data_count, exp_wr);
        check({name, "/crc_pulses"}, crc_pulses - crc0, exp_crc_v ? 1 : 0);
        if (exp_crc_v) check({name, "/crc_seen"}, seen_crc, exp_crc);
        check({name, "/crc_bytes"}, bus.crc_bytes, exp_crc);
        check({name, "/err_align"}, bus.err_align, (extra != 0) ? 1 : 0);
        check({name, "/err_short"}, bus.err_short, (pay == 1) ? 1 : 0);
        check({name, "/err_overflow"}, bus.err_overflow, (pay - 2 > MAX_DATA) ? 1 : 0);
        model_crc = exp_crc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/pid_byte"},     bus.pid_byte, 0);
        check({tag, "/pid_valid"},    bus.pid_valid, 0);
        check({tag, "/fifo_byte"},    bus.fifo_byte, 0);
        check({tag, "/fifo_wr"},      bus.fifo_wr, 0);
        check({tag, "/crc_bytes"},    bus.crc_bytes, 0);
        check({tag, "/crc_valid"},    bus.crc_valid, 0);
        check({tag, "/data_count"},   bus.data_count, 0);
        check({tag, "/err_align"},    bus.err_align, 0);
        check({tag, "/err_short"},    bus.err_short, 0);
        check({tag, "/err_overflow"}, bus.err_overflow, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int wr0, pid0;

        rst              = 1'b1;
        bus.packet_start = 1'b0;
        bus.packet_end   = 1'b0;
        bus.shift_enable = 1'b0;
        bus.bit_in       = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Bits sent in IDLE must be ignored.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("idle_ignore/pid_valid_count", pid_pulses, 0);

        q = '{8'hD2};                                  run_packet("handshake", q, 0, 0);
        q = '{8'hC3, 8'h01, 8'h02, 8'hAB, 8'hCD};      run_packet("data", q, 0, 0);
        q = '{8'hC3, 8'h55, 8'hAA, 8'h0F};             run_packet("misalign", q, 3, 0);
        q = '{8'hC3, 8'h77};                           run_packet("short", q, 0, 0);
        q = '{8'hC3, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        run_packet("overflow", q, 0, 0);
        q = '{};                                       run_packet("pid_partial", q, 5, 0);
        q = '{8'h4B, 8'h99, 8'h88, 8'h77};             run_packet("end_with_bit", q, 0, 1);

        for (int p = 0; p < 25; p++) begin
            int n;
            n = $urandom_range(0, 8);
            q = '{};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            run_packet($sformatf("rand%0d", p), q,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                       1'($urandom));
        end

        // Restart mid-DATA: held 0x11/0x22 must never be written.
        wr0  = wr_q.size();
        pid0 = pid_pulses;
        pulse_start();
        send_byte(8'hC3);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        send_byte(8'h5A);
        send_byte(8'h33);
        pulse_end(0);
        repeat (2) tick();
        check("restart/fifo_wr_count", wr_q.size() - wr0, 0);
        check("restart/pid_pulses", pid_pulses - pid0, 2);
        check("restart/pid_byte", bus.pid_byte, 8'h5A);
        check("restart/err_short", bus.err_short, 1);
        check("restart/crc_bytes", bus.crc_bytes, model_crc);

        // Leave non-zero outputs, then reset asynchronously during a PID byte.
        q = '{8'hC3, 8'h55, 8'hAA, 8'h0F};
        run_packet("pre_reset", q, 3, 0);
        pulse_start();
        for (int k = 0; k < 4; k++) send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        rst = 1'b0;
        model_crc = '0;
        tick();

        q = '{8'hE1, 8'h21, 8'h43, 8'h65};
        run_packet("after_reset", q, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
